// File: rtl/instr_fetch_unit_pkg.sv
// Shared RV32I fetch/decode definitions: opcode encodings, fetch FSM states, word helpers.
package instr_fetch_unit_pkg;

  localparam int unsigned ILEN  = 32;
  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_RTYPE  = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_ITYPE  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_STYPE  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [ILEN-1:0] word);
    return word[6:2];
  endfunction

  // RV32I base encodings always end in 2'b11; anything else is compressed or garbage.
  function automatic logic is_illegal(input logic [ILEN-1:0] word);
    return word[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction-memory handshake, branch redirect and decode-side instruction stream.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic                  imem_req_valid;
  logic [XLEN-1:0]       imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [ILEN-1:0]       imem_rsp_data;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [ILEN-1:0]       inst_data;
  logic [XLEN-1:0]       inst_pc;
  logic [OPC_W-1:0]      inst_opcode;
  logic                  inst_illegal;
  logic                  redirect_misal;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc, inst_opcode, inst_illegal, redirect_misal,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc, inst_opcode, inst_illegal, redirect_misal,
    output inst_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Two-entry instruction buffer with flush; head reads as zero when empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/count update; a push at full is accepted only alongside a pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one memory fetch at a time, buffers up to two words
// for decode and handles branch redirects (flush plus discard of one stale response).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned ENTRY_W = ILEN + XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            req_valid_q, req_valid_d;
  logic            misal_q, misal_d;

  logic               fifo_push, fifo_pop, fifo_flush;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_head;
  logic [1:0]         fifo_count;
  logic               accepted, pop_ok;
  logic [1:0]         count_after_pop, count_after_push;
  logic [ILEN-1:0]    inst_word;

  // Buffer entry is {word, pc of that word}.
  fetch_fifo #(.WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Next-state: redirect overrides everything; a pending stale response blocks new requests
  // so at most one response is ever in flight to be discarded.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    drop_d           = drop_q;
    misal_d          = 1'b0;
    fifo_push        = 1'b0;
    fifo_pop         = 1'b0;
    fifo_flush       = 1'b0;
    accepted         = req_valid_q && bus.imem_req_ready;
    pop_ok           = (fifo_count != 2'd0) && bus.inst_ready;
    count_after_pop  = fifo_count - 2'(pop_ok);
    count_after_push = count_after_pop + 2'd1;
    fifo_wdata       = {bus.imem_rsp_data, pc_q - XLEN'(4)};
    if (bus.redirect_valid) begin
      state_d    = S_REQ;
      pc_d       = {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_d     = (drop_q || (state_q == S_WAIT) || accepted) && !bus.imem_rsp_valid;
      fifo_flush = 1'b1;
      misal_d    = |bus.redirect_pc[1:0];
    end else begin
      fifo_pop = pop_ok;
      if (drop_q && bus.imem_rsp_valid) drop_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (accepted) begin
            state_d = S_WAIT;
            pc_d    = pc_q + XLEN'(4);
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid && !drop_q) begin
            fifo_push = 1'b1;
            state_d   = (count_after_push < 2'd2) ? S_REQ : S_HOLD;
          end
        end
        S_HOLD: begin
          if (count_after_pop < 2'd2) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
    req_valid_d = (state_d == S_REQ) && !drop_d;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      misal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      misal_q     <= misal_d;
    end
  end

  assign inst_word          = fifo_head[ENTRY_W-1:XLEN];
  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (fifo_count != 2'd0);
  assign bus.inst_data      = inst_word;
  assign bus.inst_pc        = fifo_head[XLEN-1:0];
  assign bus.inst_opcode    = opcode_of(inst_word);
  assign bus.inst_illegal   = (fifo_count != 2'd0) && is_illegal(inst_word);
  assign bus.redirect_misal = misal_q;

endmodule
